// File: rtl/line_clear_engine.sv
// Line clear engine: scans the playfield from bottom to top, drops full rows, compacts
// the rest downward, zero-fills the top and accumulates a saturating 4-digit BCD score.
module line_clear_engine #(
    parameter int COLS   = 10,
    parameter int ROWS   = 20,
    parameter int ROW_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic [ROW_AW-1:0] o_rd_addr,
    input  logic [COLS-1:0]   i_rd_data,
    output logic              o_wr_en,
    output logic [ROW_AW-1:0] o_wr_addr,
    output logic [COLS-1:0]   o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [4:0]        o_lines_cleared,
    output logic [15:0]       o_score_bcd,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EVAL = 3'd2,
        S_CLR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
    localparam logic [COLS-1:0]   FULL_ROW = '1;

    state_t            r_state;
    logic [ROW_AW-1:0] r_rd_ptr;
    logic [ROW_AW-1:0] r_wr_ptr;
    logic [4:0]        r_count;
    logic [ROW_AW-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_done;
    logic [4:0]        r_lines;
    logic [15:0]       r_score;

    logic              w_full;
    logic              w_eval_wr;
    logic [4:0]        w_count_next;

    function automatic logic [3:0] pts(input logic [4:0] n);
        case (n)
            5'd0:    pts = 4'd0;
            5'd1:    pts = 4'd1;
            5'd2:    pts = 4'd3;
            5'd3:    pts = 4'd5;
            default: pts = 4'd8;
        endcase
    endfunction

    // Ripple BCD add; a carry out of the thousands digit pins the score at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] s, input logic [3:0] p);
        logic [4:0]  sum;
        logic        carry;
        logic [15:0] res;
        carry = 1'b0;
        res   = '0;
        for (int i = 0; i < 4; i++) begin
            sum = {1'b0, s[4*i +: 4]} + {4'd0, carry};
            if (i == 0) begin
                sum = sum + {1'b0, p};
            end
            if (sum > 5'd9) begin
                res[4*i +: 4] = 4'(sum - 5'd10);
                carry         = 1'b1;
            end else begin
                res[4*i +: 4] = sum[3:0];
                carry         = 1'b0;
            end
        end
        bcd_add_sat = carry ? 16'h9999 : res;
    endfunction

    assign w_full       = (i_rd_data == FULL_ROW);
    assign w_count_next = r_count + {4'd0, w_full};
    // The EVAL write depends on read data arriving in the same cycle, so the write port is decoded.
    assign w_eval_wr    = (r_state == S_EVAL) && !w_full && (r_wr_ptr != r_rd_ptr);

    assign o_wr_en         = w_eval_wr || (r_state == S_CLR);
    assign o_wr_addr       = r_wr_ptr;
    assign o_wr_data       = (r_state == S_EVAL) ? i_rd_data : '0;
    assign o_rd_addr       = r_rd_addr;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_lines_cleared = r_lines;
    assign o_score_bcd     = r_score;
    assign o_state         = r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lines   <= '0;
            r_score   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_rd_ptr  <= LAST_ROW;
                        r_wr_ptr  <= LAST_ROW;
                        r_count   <= '0;
                        r_rd_addr <= LAST_ROW;
                        r_busy    <= 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_count <= w_count_next;
                    if (!w_full) begin
                        r_wr_ptr <= r_wr_ptr - 1'b1;
                    end
                    if (r_rd_ptr == '0) begin
                        if (w_count_next != 5'd0) begin
                            r_state <= S_CLR;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_rd_ptr  <= r_rd_ptr - 1'b1;
                        r_rd_addr <= r_rd_ptr - 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_CLR: begin
                    r_wr_ptr <= r_wr_ptr - 1'b1;
                    if (r_wr_ptr == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_lines <= r_count;
                    r_score <= bcd_add_sat(r_score, pts(r_count));
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
